program_memory_banked: RTL



---
 rtl/program_memory_banked.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/program_memory_banked.sv
// Dual-bank program store with an SPI mode-0 loader that fills the shadow bank.
// Latency: fetch 1 cycle; SPI edges seen SCK_SYNC+1 cycles after the pin edge.
// No backpressure: the SPI master paces the loader, and swaps wait for cpu_swap_ok.
module program_memory_banked #(
    parameter int PM_ADDR_W = 8,
    parameter int WORD_W    = 32,
    parameter int SCK_SYNC  = 2
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_reset,
    input  logic                 pm_en,
    input  logic [PM_ADDR_W-1:0] pm_addr,
    input  logic                 cpu_swap_ok,
    input  logic                 spi_sck,
    input  logic                 spi_csn,
    input  logic                 spi_mosi,
    output logic [WORD_W-1:0]    pm_data,
    output logic                 spi_miso,
    output logic                 cpu_run,
    output logic                 active_bank,
    output logic                 load_busy,
    output logic                 load_err,
    output logic                 swap_done
);
    localparam int DEPTH = 2 ** PM_ADDR_W;
    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_RESP, S_WAIT} state_t;

    state_t                 state;
    logic [SCK_SYNC-1:0]    sck_sr, csn_sr, mosi_sr;
    logic                   sck_prev;
    logic                   sck_s, csn_s, mosi_s, sck_rise, sck_fall;
    logic [WORD_W-1:0]      rx_shift;
    logic [CNT_W-1:0]       rx_bit_cnt;
    logic                   word_vld;
    logic [PM_ADDR_W-1:0]   wr_addr, n_last;
    logic [WORD_W-1:0]      acc, resp_sh;
    logic [CNT_W-1:0]       resp_cnt;
    logic                   swap_pending, swap, mem_we;
    logic [WORD_W-1:0]      mem [0:2*DEPTH-1];

    assign sck_s     = sck_sr[SCK_SYNC-1];
    assign csn_s     = csn_sr[SCK_SYNC-1];
    assign mosi_s    = mosi_sr[SCK_SYNC-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign swap      = swap_pending & cpu_swap_ok;
    assign load_busy = (state != S_IDLE);
    // csn high in the same cycle wins: that frame is being aborted
    assign mem_we    = (state == S_DATA) && word_vld && !csn_s;

    // Synchronise the asynchronous SPI pins; csn idles high
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            sck_sr   <= '0;
            csn_sr   <= '1;
            mosi_sr  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sr   <= {sck_sr[SCK_SYNC-2:0], spi_sck};
            csn_sr   <= {csn_sr[SCK_SYNC-2:0], spi_csn};
            mosi_sr  <= {mosi_sr[SCK_SYNC-2:0], spi_mosi};
            sck_prev <= sck_s;
        end
    end

    // Receive shifter: LSB first, word_vld one cycle after the last bit's rising edge
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            rx_shift   <= '0;
            rx_bit_cnt <= '0;
            word_vld   <= 1'b0;
        end else begin
            word_vld <= 1'b0;
            if (csn_s || state == S_IDLE) begin
                rx_bit_cnt <= '0;
            end else if (sck_rise) begin
                rx_shift <= {mosi_s, rx_shift[WORD_W-1:1]};
                if (rx_bit_cnt == CNT_W'(WORD_W - 1)) begin
                    rx_bit_cnt <= '0;
                    word_vld   <= 1'b1;
                end else begin
                    rx_bit_cnt <= rx_bit_cnt + 1'b1;
                end
            end
        end
    end

    // Loader writes only ever target the bank the CPU is not fetching from
    always_ff @(posedge cpu_clk) begin
        if (mem_we)
            mem[{~active_bank, wr_addr}] <= rx_shift;
    end

    // Fetch port; a swap in the same cycle still reads the old bank
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset)
            pm_data <= '0;
        else if (pm_en)
            pm_data <= mem[{active_bank, pm_addr}];
    end

    // Frame FSM plus bank swap and status flags
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state        <= S_IDLE;
            wr_addr      <= '0;
            n_last       <= '0;
            acc          <= '0;
            resp_sh      <= '0;
            resp_cnt     <= '0;
            spi_miso     <= 1'b1;
            load_err     <= 1'b0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
            cpu_run      <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (swap) begin
                active_bank  <= ~active_bank;
                cpu_run      <= 1'b1;
                swap_done    <= 1'b1;
                swap_pending <= 1'b0;
            end
            if (state != S_RESP)
                spi_miso <= 1'b1;

            if (csn_s && state != S_IDLE && state != S_WAIT) begin
                // Early csn release: whatever reached the shadow bank is never swapped in
                state        <= S_IDLE;
                load_err     <= 1'b1;
                swap_pending <= 1'b0;
                spi_miso     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (!csn_s) begin
                        state    <= S_HDR;
                        wr_addr  <= '0;
                        resp_cnt <= '0;
                    end
                    S_HDR: if (word_vld) begin
                        if (rx_shift[WORD_W-1 -: 8] == 8'hA5) begin
                            n_last       <= rx_shift[PM_ADDR_W-1:0];
                            wr_addr      <= '0;
                            acc          <= '0;
                            load_err     <= 1'b0;
                            swap_pending <= 1'b0;
                            state        <= S_DATA;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                    S_DATA: if (word_vld) begin
                        acc     <= acc + rx_shift;
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_addr == n_last)
                            state <= S_CHK;
                    end
                    S_CHK: if (word_vld) begin
                        if (rx_shift == acc)
                            swap_pending <= 1'b1;
                        else
                            load_err <= 1'b1;
                        resp_sh  <= acc;
                        resp_cnt <= '0;
                        state    <= S_RESP;
                    end
                    S_RESP: if (sck_fall) begin
                        // The fall closing the checksum word presents bit 0; the master
                        // then clocks WORD_W bits and its last fall releases miso.
                        if (resp_cnt == CNT_W'(WORD_W)) begin
                            state    <= S_WAIT;
                            spi_miso <= 1'b1;
                        end else begin
                            spi_miso <= resp_sh[0];
                            resp_sh  <= resp_sh >> 1;
                            resp_cnt <= resp_cnt + 1'b1;
                        end
                    end
                    S_WAIT: if (csn_s) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
